if_stage_ctrl: RTL and testbench
================================

Name: if_stage_ctrl

Overview:
- Fetch stage plus IF/ID pipeline register for the 5-stage MIPS core. Directly upstream of the ID-stage hazard detection logic.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched instruction into IF/ID.
- Consumes the ID-stage `hazard_detected` signal as `freeze` (holds PC and IF/ID), and the EXE-stage branch resolution (redirects PC, squashes IF/ID).
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- WORD_LEN, 32, width of PC, addresses and instructions.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.
- CNT_WIDTH, 16, width of each event counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  stall request from hazard detection (hazard_detected).
- branch_taken  input  1  EXE stage resolved a taken branch/jump this cycle.
- branch_addr  input  WORD_LEN  branch target from EXE; valid when branch_taken=1.
- instr_in  input  WORD_LEN  instruction memory read data; combinational function of instr_addr.
- instr_addr  output  WORD_LEN  current PC, driven to instruction memory.
- PC_ID  output  WORD_LEN  PC+4 of the instruction held in IF/ID.
- instruction_ID  output  WORD_LEN  instruction held in IF/ID.
- valid_ID  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- stall_count  output  CNT_WIDTH  cycles spent frozen.
- flush_count  output  CNT_WIDTH  taken-branch flush events.

Behaviour:
- All state is registered.
- instr_addr is the PC register output, with no combinational path from any input. instruction_ID, PC_ID and valid_ID are direct register outputs.
- Reset (rst=1 at clock edge, highest priority, may assert at any time including mid-freeze or mid-branch):
  - PC=RESET_PC.
  - instruction_ID=0, PC_ID=0, valid_ID=0.
  - stall_count=0, flush_count=0.
- Per-cycle priority when rst=0: branch_taken > freeze > advance.
- Branch (branch_taken=1, regardless of freeze):
  - PC <= {branch_addr[WORD_LEN-1:2], 2'b00}.
  - IF/ID squashed: instruction_ID <= 0 (NOP), PC_ID <= 0, valid_ID <= 0.
  - flush_count += 1.
  - A frozen ID instruction is wrong-path, so the branch overrides freeze.
- Freeze (freeze=1, branch_taken=0):
  - PC, instruction_ID, PC_ID and valid_ID all hold.
  - stall_count += 1.
- Advance (both 0):
  - instruction_ID <= instr_in.
  - PC_ID <= PC+4.
  - valid_ID <= 1.
  - PC <= PC+4.
- Arithmetic: PC+4 is modulo 2^WORD_LEN, so 0xFFFFFFFC advances to 0x00000000 with no flag.
- Counters: saturate at all-ones and never wrap; both counters are cleared only by rst.
- Latency: the instruction at instr_addr in cycle n appears on instruction_ID in cycle n+1 if cycle n advances. A branch asserted in cycle n makes instr_addr=target in cycle n+1, and the target instruction reaches ID in cycle n+2.
- Freeze of any length holds state indefinitely. Freeze dropping resumes fetch at the held PC, so no instruction is lost or duplicated.
- X on freeze/branch_taken while rst=1 is ignored.

Test Plan:
1. Reset then sequential fetch: rst=1 one cycle, RESET_PC=0, memory returns addr-based words -> instr_addr goes 0,4,8,12. instruction_ID=mem[0] with PC_ID=4 and valid_ID=1 in the cycle after the first advance. Counters remain 0.
2. Freeze 3 cycles while PC=8, IF/ID holding mem[4] -> instr_addr stays 8, instruction_ID stays mem[4], stall_count=3. After release, instruction_ID=mem[8] and PC=12.
3. Taken branch, branch_addr=0x40 while PC=0x10 -> next cycle instr_addr=0x40, instruction_ID=0, valid_ID=0, flush_count=1. One cycle later instruction_ID=mem[0x40], PC_ID=0x44.
4. freeze=1 and branch_taken=1 together, branch_addr=0x83 -> PC=0x80, IF/ID squashed, flush_count+1, stall_count unchanged.
5. Reset mid-freeze, and PC wrap:
   - rst during 2nd freeze cycle -> all outputs at reset values next cycle.
   - Separately, branch to 0xFFFFFFFC then advance -> instr_addr=0x00000000.
6. Counter saturation with CNT_WIDTH=2: hold freeze 6 cycles -> stall_count reads 1,2,3,3,3,3. Same check for flush_count with 5 consecutive branches.

Source files
------------

// File: rtl/if_stage_ctrl.sv
// rtl/if_stage_ctrl.sv - fetch stage: PC, IF/ID pipeline register and stall/flush counters
module if_stage_ctrl #(
    parameter int                  WORD_LEN  = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 branch_taken,
    input  logic [WORD_LEN-1:0]  branch_addr,
    input  logic [WORD_LEN-1:0]  instr_in,
    output logic [WORD_LEN-1:0]  instr_addr,
    output logic [WORD_LEN-1:0]  PC_ID,
    output logic [WORD_LEN-1:0]  instruction_ID,
    output logic                 valid_ID,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] pc_plus4;

    // Modulo-2^WORD_LEN increment: wraps silently past the top of memory.
    assign pc_plus4   = pc + WORD_LEN'(4);
    assign instr_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            instruction_ID <= '0;
            PC_ID          <= '0;
            valid_ID       <= 1'b0;
        end else if (branch_taken) begin
            // A frozen ID instruction is wrong-path, so the branch beats freeze.
            pc             <= {branch_addr[WORD_LEN-1:2], 2'b00};
            instruction_ID <= '0;
            PC_ID          <= '0;
            valid_ID       <= 1'b0;
        end else if (!freeze) begin
            pc             <= pc_plus4;
            instruction_ID <= instr_in;
            PC_ID          <= pc_plus4;
            valid_ID       <= 1'b1;
        end
    end

    // Event counters saturate at all-ones so long runs never alias to small values.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (branch_taken) begin
            if (flush_count != '1) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end else if (freeze) begin
            if (stall_count != '1) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_stage_ctrl.sv
// tb/tb_if_stage_ctrl.sv - scoreboard bench for if_stage_ctrl with a reference model
module tb_if_stage_ctrl;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          freeze = 1'b0;
    logic          branch_taken = 1'b0;
    logic [31:0]   branch_addr = '0;
    logic [31:0]   instr_in;
    logic [31:0]   instr_addr;
    logic [31:0]   PC_ID;
    logic [31:0]   instruction_ID;
    logic          valid_ID;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc_id;
        logic [31:0] instr;
        logic        v;
        int          sc;
        int          fc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pc_id;
    logic [31:0] m_instr;
    logic        m_v;
    int          m_sc;
    int          m_fc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0F96;
    endfunction

    assign instr_in = mem_word(instr_addr);

    always #5 clk = ~clk;

    if_stage_ctrl #(.WORD_LEN(32), .RESET_PC(32'h0), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .instr_in(instr_in), .instr_addr(instr_addr),
        .PC_ID(PC_ID), .instruction_ID(instruction_ID), .valid_ID(valid_ID),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
        exp_t e;
        @(negedge clk);
        rst = r; freeze = f; branch_taken = b; branch_addr = ba;
        if (r) begin
            m_pc = 32'h0; m_pc_id = 0; m_instr = 0; m_v = 0; m_sc = 0; m_fc = 0;
        end else if (b) begin
            m_pc = ba & 32'hFFFF_FFFC; m_pc_id = 0; m_instr = 0; m_v = 0;
            m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        end else if (f) begin
            m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        end else begin
            m_instr = mem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc_id = m_pc;
            m_v     = 1'b1;
        end
        e.addr = m_pc; e.pc_id = m_pc_id; e.instr = m_instr; e.v = m_v; e.sc = m_sc; e.fc = m_fc;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("instr_addr", instr_addr, mon_e.addr);
                chk("PC_ID", PC_ID, mon_e.pc_id);
                chk("instruction_ID", instruction_ID, mon_e.instr);
                chk("valid_ID", {31'b0, valid_ID}, {31'b0, mon_e.v});
                chk("stall_count", 32'(stall_count), 32'(mon_e.sc));
                chk("flush_count", 32'(flush_count), 32'(mon_e.fc));
            end
        end
    end

    initial begin
        int r;
        // Reset then sequential fetch
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        // Freeze with PC=8, IF/ID holding mem[4]
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        // Taken branch at PC=0x10
        step(0, 0, 1, 32'h40);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        // Branch and freeze together, misaligned target
        step(0, 1, 1, 32'h83);
        step(0, 0, 0, 0);
        // Reset during second freeze cycle
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        // Stall counter saturation
        step(1, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0);
        // Flush counter saturation
        step(1, 0, 0, 0);
        repeat (5) step(0, 0, 1, $urandom);
        step(0, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(99);
            step(r < 3, $urandom_range(99) < 35, $urandom_range(99) < 12,
                 ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15)) : $urandom);
        end
        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
